// File: rtl/boot_loader.sv
// Byte-stream boot loader: packs LE words into instruction memory, then releases the core reset.
// Optional trailing XOR checksum byte enabled by defining BOOT_CHECKSUM_EN.
module boot_loader #(
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned ADDR_W  = $clog2(DEPTH),
  parameter int unsigned TIMEOUT = 65535
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_wr_en,
  output logic [ADDR_W-1:0] imem_wr_addr,
  output logic [31:0]       imem_wr_data,
  output logic              cpu_rst_n,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_loaded
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam int unsigned TO_W  = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
`ifdef BOOT_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  typedef enum logic [2:0] {S_LEN, S_DATA, S_CSUM, S_RUN, S_ERR} state_t;

  state_t            state_q;
  logic [1:0]        byte_cnt_q;
  logic [23:0]       word_q;
  logic [CNT_W-1:0]  n_q;
  logic [CNT_W-1:0]  words_q;
  logic [TO_W-1:0]   idle_q;
  logic              started_q;
  logic [7:0]        csum_q;
  logic              ready_q;
  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [31:0]       wr_data_q;
  logic              cpu_rst_n_q;
  logic              done_q;
  logic              error_q;

  logic        hs;
  logic        idle_en;
  logic        last_lane;
  logic [31:0] full_word;

  assign hs        = in_valid & ready_q;
  assign last_lane = (byte_cnt_q == 2'd3);
  assign full_word = {in_data, word_q};
  assign idle_en   = ((state_q == S_LEN) && started_q) ||
                     (state_q == S_DATA) || (state_q == S_CSUM);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_LEN;
      byte_cnt_q  <= 2'd0;
      word_q      <= '0;
      n_q         <= '0;
      words_q     <= '0;
      idle_q      <= '0;
      started_q   <= 1'b0;
      csum_q      <= 8'd0;
      ready_q     <= 1'b1;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= 32'd0;
      cpu_rst_n_q <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      wr_en_q <= 1'b0;

      // Byte lane packing and idle tracking common to every accepting state
      if (hs) begin
        idle_q     <= '0;
        byte_cnt_q <= byte_cnt_q + 2'd1;
        case (byte_cnt_q)
          2'd0:    word_q[7:0]   <= in_data;
          2'd1:    word_q[15:8]  <= in_data;
          2'd2:    word_q[23:16] <= in_data;
          default: ;
        endcase
      end else if (idle_en && (TIMEOUT != 0)) begin
        if (32'(idle_q) + 32'd1 >= TIMEOUT) begin
          state_q <= S_ERR;
          ready_q <= 1'b0;
          error_q <= 1'b1;
        end else begin
          idle_q <= idle_q + TO_W'(1);
        end
      end

      case (state_q)
        S_LEN: begin
          if (hs) begin
            started_q <= 1'b1;
            if (last_lane) begin
              if (full_word > 32'(DEPTH)) begin
                state_q <= S_ERR;
                ready_q <= 1'b0;
                error_q <= 1'b1;
              end else if (full_word == 32'd0) begin
                if (CSUM_EN) begin
                  state_q <= S_CSUM;
                end else begin
                  state_q <= S_RUN;
                  ready_q <= 1'b0;
                end
              end else begin
                n_q     <= CNT_W'(full_word);
                state_q <= S_DATA;
              end
            end
          end
        end
        S_DATA: begin
          if (hs) begin
            csum_q <= csum_q ^ in_data;
            if (last_lane) begin
              wr_en_q   <= 1'b1;
              wr_addr_q <= words_q[ADDR_W-1:0];
              wr_data_q <= full_word;
              words_q   <= words_q + CNT_W'(1);
              if (words_q + CNT_W'(1) == n_q) begin
                if (CSUM_EN) begin
                  state_q <= S_CSUM;
                end else begin
                  state_q <= S_RUN;
                  ready_q <= 1'b0;
                end
              end
            end
          end
        end
        S_CSUM: begin
          if (hs) begin
            ready_q <= 1'b0;
            if (in_data == csum_q) begin
              state_q <= S_RUN;
            end else begin
              state_q <= S_ERR;
              error_q <= 1'b1;
            end
          end
        end
        S_RUN: begin
          done_q      <= 1'b1;
          cpu_rst_n_q <= 1'b1;
        end
        default: begin
          error_q <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready     = ready_q;
  assign imem_wr_en   = wr_en_q;
  assign imem_wr_addr = wr_addr_q;
  assign imem_wr_data = wr_data_q;
  assign cpu_rst_n    = cpu_rst_n_q;
  assign done         = done_q;
  assign error        = error_q;
  assign words_loaded = words_q;

endmodule
